mem_scrub_reader: RTL and testbench



---
 rtl/mem_scrub_pkg.sv | 41 ++++
 rtl/scrub_lat_pipe.sv | 38 +++
 rtl/mem_scrub_reader.sv | 153 +++++++++++++++
 tb/tb_mem_scrub_reader.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_scrub_pkg.sv
// Shared types and helpers for the read-only memory scrubber.
package mem_scrub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scrub_state_e;

  typedef enum logic [1:0] {
    PAT_NONE  = 2'd0,
    PAT_COUNT = 2'd1,
    PAT_BYTE  = 2'd2
  } pattern_e;

  localparam logic [31:0] COUNT_STEP = 32'h1111;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_ADDR_W = 32;

  // Word is built at full width; callers mask it down to their DATA_W.
  function automatic logic [MAX_DATA_W-1:0] exp_word(input logic [MAX_ADDR_W-1:0] addr,
                                                     input pattern_e pattern);
    logic [MAX_DATA_W-1:0] w;
    case (pattern)
      PAT_COUNT: w = MAX_DATA_W'(64'(addr) * 64'(COUNT_STEP));
      PAT_BYTE:  w = {(MAX_DATA_W/8){addr[7:0]}};
      default:   w = '0;
    endcase
    return w;
  endfunction

  function automatic pattern_e decode_pattern(input logic [1:0] sel);
    case (sel)
      2'd1:    return PAT_COUNT;
      2'd2:    return PAT_BYTE;
      default: return PAT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/scrub_lat_pipe.sv
// Tag shift register that tracks each read until its data is valid at the memory output.
module scrub_lat_pipe
  import mem_scrub_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              any_valid
);

  logic [DEPTH-1:0]  vld;
  logic [ADDR_W-1:0] adr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) adr[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      adr[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_addr  = adr[DEPTH-1];
  assign any_valid = |vld;

endmodule

// File: rtl/mem_scrub_reader.sv
// Read-only sweep of a memory range, tallying CRC flags and pattern mismatches.
// state | meaning
// IDLE  | waiting for start after reset
// ISSUE | one read address per cycle until last_addr or abort
// DRAIN | no new reads, waiting for in-flight tags to retire
// DONE  | results held until the next start
module mem_scrub_reader
  import mem_scrub_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [1:0]        pattern_sel,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_err_detected,
  input  logic              mem_err_corrected,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  det_cnt,
  output logic [CNT_W-1:0]  cor_cnt,
  output logic [CNT_W-1:0]  mis_cnt,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [MAX_DATA_W-1:0] DATA_MASK = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - DATA_W);

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] last_q;
  pattern_e          pat_q;
  logic              load, issue, enter_done;
  logic              pipe_valid, pipe_any;
  logic [ADDR_W-1:0] pipe_addr;
  logic [MAX_DATA_W-1:0] exp_full;
  logic              hit_mis, hit_fail;

  assign mem_wr = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // abort beats last-address detection and any concurrent start
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = ISSUE;
      ISSUE:      if (abort || mem_addr == last_q) state_d = DRAIN;
      DRAIN:      if (!pipe_any) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    load  = 1'b0;
    issue = 1'b0;
    case (state_q)
      IDLE, DONE: load = start;
      ISSUE: begin
        busy  = 1'b1;
        issue = !abort;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  assign enter_done = (state_q == DRAIN) && (state_d == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      last_q   <= '0;
      pat_q    <= PAT_NONE;
      done     <= 1'b0;
    end else begin
      done <= enter_done;
      if (load) begin
        mem_addr <= first_addr;
        last_q   <= last_addr;
        pat_q    <= decode_pattern(pattern_sel);
      end else if (issue) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

  scrub_lat_pipe #(
    .DEPTH  (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_addr   (mem_addr),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr),
    .any_valid (pipe_any)
  );

  assign exp_full = exp_word(MAX_ADDR_W'(pipe_addr), pat_q);
  assign hit_mis  = (pat_q != PAT_NONE) && ((exp_full & DATA_MASK) != MAX_DATA_W'(mem_data_out));
  assign hit_fail = mem_err_detected || hit_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid        <= 1'b0;
      rd_addr         <= '0;
      rd_data         <= '0;
      det_cnt         <= '0;
      cor_cnt         <= '0;
      mis_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else begin
      rd_valid <= pipe_valid;
      if (load) begin
        det_cnt         <= '0;
        cor_cnt         <= '0;
        mis_cnt         <= '0;
        first_err_valid <= 1'b0;
        first_err_addr  <= '0;
      end
      if (pipe_valid) begin
        rd_addr <= pipe_addr;
        rd_data <= mem_data_out;
        if (mem_err_detected && det_cnt != '1)  det_cnt <= det_cnt + CNT_W'(1);
        if (mem_err_corrected && cor_cnt != '1) cor_cnt <= cor_cnt + CNT_W'(1);
        if (hit_mis && mis_cnt != '1)           mis_cnt <= mis_cnt + CNT_W'(1);
        if (hit_fail && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= pipe_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_scrub_reader.sv
// Self-checking bench: two scrubbers (RD_LAT 1 / 8-bit addr, RD_LAT 3 / 17-bit addr) on a behavioural memory.
module tb_mem_scrub_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        rst_a [2];
  logic        start_a [2];
  logic        abort_a [2];
  logic [16:0] cfg_first, cfg_last;
  logic [1:0]  cfg_pat;

  // instance 0: ADDR_W 8, RD_LAT 1
  logic        wr0, rv0, dn0, bz0, fev0, mdet0, mcor0;
  logic [7:0]  ma0, ra0, fea0;
  logic [31:0] rd0, mdo0;
  logic [15:0] det0, cor0, mis0;
  // instance 1: ADDR_W 17, RD_LAT 3
  logic        wr1, rv1, dn1, bz1, fev1, mdet1, mcor1;
  logic [16:0] ma1, ra1, fea1;
  logic [31:0] rd1, mdo1;
  logic [15:0] det1, cor1, mis1;

  mem_scrub_reader #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst_a[0]), .start(start_a[0]), .abort(abort_a[0]),
    .first_addr(cfg_first[7:0]), .last_addr(cfg_last[7:0]), .pattern_sel(cfg_pat),
    .mem_wr(wr0), .mem_addr(ma0), .mem_data_out(mdo0),
    .mem_err_detected(mdet0), .mem_err_corrected(mcor0),
    .busy(bz0), .done(dn0), .rd_valid(rv0), .rd_addr(ra0), .rd_data(rd0),
    .det_cnt(det0), .cor_cnt(cor0), .mis_cnt(mis0),
    .first_err_valid(fev0), .first_err_addr(fea0));

  mem_scrub_reader #(.ADDR_W(17), .DATA_W(32), .RD_LAT(3), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst_a[1]), .start(start_a[1]), .abort(abort_a[1]),
    .first_addr(cfg_first), .last_addr(cfg_last), .pattern_sel(cfg_pat),
    .mem_wr(wr1), .mem_addr(ma1), .mem_data_out(mdo1),
    .mem_err_detected(mdet1), .mem_err_corrected(mcor1),
    .busy(bz1), .done(dn1), .rd_valid(rv1), .rd_addr(ra1), .rd_data(rd1),
    .det_cnt(det1), .cor_cnt(cor1), .mis_cnt(mis1),
    .first_err_valid(fev1), .first_err_addr(fea1));

  logic        v_rv [2], v_done [2], v_busy [2], v_fev [2], v_wr [2];
  logic [16:0] v_mem_addr [2], v_rd_addr [2], v_fea [2];
  logic [31:0] v_rd_data [2];
  logic [15:0] v_det [2], v_cor [2], v_mis [2];

  always_comb begin
    v_rv[0] = rv0;   v_done[0] = dn0;  v_busy[0] = bz0;  v_fev[0] = fev0;  v_wr[0] = wr0;
    v_rv[1] = rv1;   v_done[1] = dn1;  v_busy[1] = bz1;  v_fev[1] = fev1;  v_wr[1] = wr1;
    v_mem_addr[0] = 17'(ma0);  v_rd_addr[0] = 17'(ra0);  v_fea[0] = 17'(fea0);
    v_mem_addr[1] = ma1;       v_rd_addr[1] = ra1;       v_fea[1] = fea1;
    v_rd_data[0] = rd0;  v_det[0] = det0;  v_cor[0] = cor0;  v_mis[0] = mis0;
    v_rd_data[1] = rd1;  v_det[1] = det1;  v_cor[1] = cor1;  v_mis[1] = mis1;
  end

  // Behavioural memory: 256-word image (indexed by addr[7:0]) with error maps and fixed latency.
  logic [31:0] mem_img [256];
  bit          det_map [256];
  bit          cor_map [256];
  bit          det_all = 1'b0;
  logic [7:0]  h0 = 8'd0;
  logic [16:0] h1 [3] = '{17'd0, 17'd0, 17'd0};

  always @(posedge clk) begin
    h0    <= ma0;
    h1[0] <= ma1;
    h1[1] <= h1[0];
    h1[2] <= h1[1];
  end

  assign mdo0  = mem_img[h0];
  assign mdet0 = det_all | det_map[h0];
  assign mcor0 = cor_map[h0];
  assign mdo1  = mem_img[h1[2][7:0]];
  assign mdet1 = det_all | det_map[h1[2][7:0]];
  assign mcor1 = cor_map[h1[2][7:0]];

  // Reference model state
  logic [16:0] exp_addr [$];
  logic [31:0] exp_data [$];
  int          exp_done, exp_det, exp_cor, exp_mis;
  bit          exp_fev;
  logic [16:0] exp_fea;

  logic [16:0] got_addr [$];
  logic [31:0] got_data [$];
  int          got_done;

  function automatic logic [31:0] pat_word(input logic [16:0] a, input logic [1:0] ps);
    if (ps == 2'd1) return 32'(a * 32'h1111);
    if (ps == 2'd2) return 32'(a[7:0]) * 32'h0101_0101;
    return 32'h0;
  endfunction

  task automatic fill_mem(input logic [1:0] ps, input int corrupt_pct);
    for (int a = 0; a < 256; a++) begin
      mem_img[a] = (ps == 2'd1 || ps == 2'd2) ? pat_word(17'(a), ps) : $urandom;
      if (int'($urandom_range(99)) < corrupt_pct)
        mem_img[a] = mem_img[a] ^ (32'h1 << $urandom_range(31));
      det_map[a] = 1'b0;
      cor_map[a] = 1'b0;
    end
  endtask

  task automatic model_sweep(input int d, input logic [16:0] fa, la, input logic [1:0] ps,
                             input int abort_cyc);
    logic [16:0] mask, a;
    logic [31:0] w;
    int len, n;
    bit det, cor, mis;
    mask = (d == 0) ? 17'h000FF : 17'h1FFFF;
    len  = int'((la - fa) & mask) + 1;
    n    = (abort_cyc > 0 && abort_cyc <= len) ? abort_cyc - 1 : len;
    exp_done = (n == 0) ? 3 : n + ((d == 0) ? 1 : 3) + 2;
    exp_addr.delete(); exp_data.delete();
    exp_det = 0; exp_cor = 0; exp_mis = 0; exp_fev = 1'b0; exp_fea = '0;
    for (int i = 0; i < n; i++) begin
      a   = (fa + 17'(i)) & mask;
      w   = mem_img[a[7:0]];
      det = det_all || det_map[a[7:0]];
      cor = cor_map[a[7:0]];
      mis = (ps == 2'd1 || ps == 2'd2) && (w != pat_word(a, ps));
      exp_addr.push_back(a);
      exp_data.push_back(w);
      if (det && exp_det < 65535) exp_det++;
      if (cor && exp_cor < 65535) exp_cor++;
      if (mis && exp_mis < 65535) exp_mis++;
      if ((det || mis) && !exp_fev) begin
        exp_fev = 1'b1;
        exp_fea = a;
      end
    end
  endtask

  // Pulses start, then records every rd_valid beat until done (bounded by budget).
  task automatic run_sweep(input int d, input logic [16:0] fa, la, input logic [1:0] ps,
                           input int abort_cyc, restart_cyc, budget);
    got_addr.delete(); got_data.delete();
    got_done = -1;
    @(negedge clk);
    cfg_first = fa; cfg_last = la; cfg_pat = ps;
    start_a[d] = 1'b1;
    @(negedge clk);
    start_a[d] = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      abort_a[d] = (cyc == abort_cyc);
      start_a[d] = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        cfg_first = fa + 17'd50;
        cfg_last  = fa + 17'd50;
      end
      if (v_rv[d]) begin
        got_addr.push_back(v_rd_addr[d]);
        got_data.push_back(v_rd_data[d]);
      end
      if (v_done[d]) begin
        got_done = cyc;
        break;
      end
      @(negedge clk);
    end
    abort_a[d] = 1'b0;
    start_a[d] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({v_busy[d], v_done[d], v_rv[d], v_wr[d], v_fev[d], v_mem_addr[d], v_rd_addr[d],
           v_rd_data[d], v_det[d], v_cor[d], v_mis[d], v_fea[d]} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got busy=%b done=%b rd_valid=%b mem_addr=%h det=%h, required all zero",
                 d, v_busy[d], v_done[d], v_rv[d], v_mem_addr[d], v_det[d]);
      end
    end
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;
  endtask

  task automatic test_count_clean();
    bit bad;
    fill_mem(2'd1, 0);
    model_sweep(0, 17'd0, 17'd15, 2'd1, 0);
    run_sweep(0, 17'd0, 17'd15, 2'd1, 0, 0, 200);
    bad = (got_addr.size() != 16);
    for (int i = 0; i < got_addr.size() && !bad; i++)
      bad = (got_addr[i] !== exp_addr[i]) || (got_data[i] !== exp_data[i]);
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL count_clean stream: got %0d beats, required 16 beats 0..15 with memory data", got_addr.size());
    end
    vectors++;
    if (got_done !== 19) begin
      miscompares++;
      $display("FAIL count_clean done_cycle: got %0d required 19", got_done);
    end
    vectors++;
    if ({v_det[0], v_cor[0], v_mis[0], v_fev[0]} !== '0) begin
      miscompares++;
      $display("FAIL count_clean counters: got det=%0d cor=%0d mis=%0d fev=%b required all 0",
               v_det[0], v_cor[0], v_mis[0], v_fev[0]);
    end
    @(negedge clk);
    vectors++;
    if (v_done[0] !== 1'b0 || v_busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL count_clean done_pulse: got done=%b busy=%b one cycle later, required 0 0", v_done[0], v_busy[0]);
    end
  endtask

  task automatic test_errors();
    fill_mem(2'd1, 0);
    det_map[5] = 1'b1;
    cor_map[9] = 1'b1;
    run_sweep(0, 17'd0, 17'd15, 2'd1, 0, 0, 200);
    vectors++;
    if (v_det[0] !== 16'd1 || v_cor[0] !== 16'd1 || v_mis[0] !== 16'd0) begin
      miscompares++;
      $display("FAIL errors counts: got det=%0d cor=%0d mis=%0d required 1 1 0", v_det[0], v_cor[0], v_mis[0]);
    end
    vectors++;
    if (v_fev[0] !== 1'b1 || v_fea[0] !== 17'd5) begin
      miscompares++;
      $display("FAIL errors first_err: got valid=%b addr=%0d required 1 5", v_fev[0], v_fea[0]);
    end
  endtask

  task automatic test_byte_mismatch();
    fill_mem(2'd2, 0);
    mem_img[3] = 32'h0303_0303 ^ 32'h1;
    run_sweep(0, 17'd0, 17'd15, 2'd2, 0, 0, 200);
    vectors++;
    if (v_mis[0] !== 16'd1 || v_det[0] !== 16'd0) begin
      miscompares++;
      $display("FAIL byte_mismatch counts: got mis=%0d det=%0d required 1 0", v_mis[0], v_det[0]);
    end
    vectors++;
    if (v_fev[0] !== 1'b1 || v_fea[0] !== 17'd3) begin
      miscompares++;
      $display("FAIL byte_mismatch first_err: got valid=%b addr=%0d required 1 3", v_fev[0], v_fea[0]);
    end
  endtask

  task automatic test_wrap();
    bit bad;
    fill_mem(2'd1, 0);
    model_sweep(0, 17'd250, 17'd4, 2'd1, 0);
    run_sweep(0, 17'd250, 17'd4, 2'd1, 0, 0, 200);
    bad = (got_addr.size() != 11) || (exp_addr.size() != 11);
    for (int i = 0; i < got_addr.size() && !bad; i++)
      bad = (got_addr[i] !== exp_addr[i]) || (got_data[i] !== exp_data[i]);
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL wrap stream: got %0d beats, required 11 beats 250..255,0..4", got_addr.size());
    end
    vectors++;
    if (got_done !== 14) begin
      miscompares++;
      $display("FAIL wrap done_cycle: got %0d required 14", got_done);
    end
  endtask

  task automatic test_abort();
    fill_mem(2'd1, 0);
    model_sweep(1, 17'd20, 17'd40, 2'd1, 3);
    run_sweep(1, 17'd20, 17'd40, 2'd1, 3, 0, 200);
    vectors++;
    if (got_addr.size() != 2 || got_addr[0] !== 17'd20 || got_addr[1] !== 17'd21) begin
      miscompares++;
      $display("FAIL abort beats: got %0d beats, required 2 beats 20,21", got_addr.size());
    end
    vectors++;
    if (got_done !== exp_done) begin
      miscompares++;
      $display("FAIL abort done_cycle: got %0d required %0d", got_done, exp_done);
    end
  endtask

  task automatic test_start_busy();
    model_sweep(0, 17'd10, 17'd19, 2'd1, 0);
    run_sweep(0, 17'd10, 17'd19, 2'd1, 0, 4, 200);
    vectors++;
    if (got_addr.size() != exp_addr.size() || got_done !== exp_done) begin
      miscompares++;
      $display("FAIL start_busy: got %0d beats done@%0d, required %0d beats done@%0d",
               got_addr.size(), got_done, exp_addr.size(), exp_done);
    end
    model_sweep(0, 17'd10, 17'd19, 2'd1, 4);
    run_sweep(0, 17'd10, 17'd19, 2'd1, 4, 4, 200);
    vectors++;
    if (got_addr.size() != 3 || got_done !== exp_done) begin
      miscompares++;
      $display("FAIL abort_start_same_cycle: got %0d beats done@%0d, required 3 beats done@%0d",
               got_addr.size(), got_done, exp_done);
    end
  endtask

  task automatic test_rst_drain();
    @(negedge clk);
    cfg_first = 17'd0; cfg_last = 17'd7; cfg_pat = 2'd0;
    start_a[1] = 1'b1;
    @(negedge clk);
    start_a[1] = 1'b0;
    repeat (9) @(negedge clk);
    vectors++;
    if (v_busy[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_drain busy_before: got %b required 1", v_busy[1]);
    end
    rst_a[1] = 1'b1;
    @(negedge clk);
    rst_a[1] = 1'b0;
    vectors++;
    if ({v_busy[1], v_done[1], v_rv[1], v_fev[1], v_mem_addr[1], v_rd_addr[1],
         v_rd_data[1], v_det[1], v_cor[1], v_mis[1], v_fea[1]} !== '0) begin
      miscompares++;
      $display("FAIL rst_drain outputs: got busy=%b rd_valid=%b mem_addr=%h rd_addr=%h required all zero",
               v_busy[1], v_rv[1], v_mem_addr[1], v_rd_addr[1]);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (v_rv[1] !== 1'b0 || v_done[1] !== 1'b0 || v_busy[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_drain flushed: got rd_valid=%b done=%b busy=%b required 0 0 0", v_rv[1], v_done[1], v_busy[1]);
    end
  endtask

  task automatic test_random();
    bit bad;
    int d, len, abort_cyc;
    logic [16:0] fa, la;
    logic [1:0] ps;
    for (int it = 0; it < 12; it++) begin
      d   = int'($urandom_range(1));
      fa  = (d == 0) ? 17'($urandom_range(255)) : 17'($urandom_range(200));
      len = int'($urandom_range(40, 1));
      la  = (d == 0) ? ((fa + 17'(len - 1)) & 17'h000FF) : (fa + 17'(len - 1));
      ps  = 2'($urandom_range(3));
      fill_mem(ps, 15);
      for (int a = 0; a < 256; a++) begin
        det_map[a] = ($urandom_range(9) == 0);
        cor_map[a] = ($urandom_range(9) == 0);
      end
      abort_cyc = ($urandom_range(3) == 0) ? int'($urandom_range(len + 3, 2)) : 0;
      model_sweep(d, fa, la, ps, abort_cyc);
      run_sweep(d, fa, la, ps, abort_cyc, 0, 300);
      bad = (got_addr.size() != exp_addr.size());
      for (int i = 0; i < got_addr.size() && !bad; i++)
        bad = (got_addr[i] !== exp_addr[i]) || (got_data[i] !== exp_data[i]);
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL random[%0d] stream: got %0d beats required %0d (dut %0d, %0d..%0d)",
                 it, got_addr.size(), exp_addr.size(), d, fa, la);
      end
      vectors++;
      if (got_done !== exp_done) begin
        miscompares++;
        $display("FAIL random[%0d] done_cycle: got %0d required %0d", it, got_done, exp_done);
      end
      vectors++;
      if (v_det[d] !== 16'(exp_det) || v_cor[d] !== 16'(exp_cor) || v_mis[d] !== 16'(exp_mis)) begin
        miscompares++;
        $display("FAIL random[%0d] counts: got det=%0d cor=%0d mis=%0d required %0d %0d %0d",
                 it, v_det[d], v_cor[d], v_mis[d], exp_det, exp_cor, exp_mis);
      end
      vectors++;
      if (v_fev[d] !== exp_fev || (exp_fev && v_fea[d] !== exp_fea)) begin
        miscompares++;
        $display("FAIL random[%0d] first_err: got valid=%b addr=%0d required %b %0d",
                 it, v_fev[d], v_fea[d], exp_fev, exp_fea);
      end
    end
  endtask

  task automatic test_saturate();
    fill_mem(2'd0, 0);
    det_all = 1'b1;
    run_sweep(1, 17'd0, 17'd69999, 2'd0, 0, 0, 70100);
    det_all = 1'b0;
    vectors++;
    if (v_det[1] !== 16'hFFFF || v_cor[1] !== 16'd0) begin
      miscompares++;
      $display("FAIL saturate det_cnt: got det=%h cor=%h required ffff 0000", v_det[1], v_cor[1]);
    end
    vectors++;
    if (got_addr.size() != 70000 || got_done !== 70005) begin
      miscompares++;
      $display("FAIL saturate length: got %0d beats done@%0d required 70000 beats done@70005",
               got_addr.size(), got_done);
    end
    vectors++;
    if (v_fev[1] !== 1'b1 || v_fea[1] !== 17'd0) begin
      miscompares++;
      $display("FAIL saturate first_err: got valid=%b addr=%0d required 1 0", v_fev[1], v_fea[1]);
    end
  endtask

  initial begin
    rst_a   = '{1'b1, 1'b1};
    start_a = '{1'b0, 1'b0};
    abort_a = '{1'b0, 1'b0};
    cfg_first = '0; cfg_last = '0; cfg_pat = '0;
    for (int a = 0; a < 256; a++) begin
      mem_img[a] = '0;
      det_map[a] = 1'b0;
      cor_map[a] = 1'b0;
    end
    repeat (2) @(posedge clk);
    test_reset();
    test_count_clean();
    test_errors();
    test_byte_mismatch();
    test_wrap();
    test_abort();
    test_start_busy();
    test_rst_drain();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
